// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and default widths for the 10110 scan controller
package seq_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int IDX_W_DEF  = 4;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/seq_hit_counter.sv
// rtl/seq_hit_counter.sv - saturating match counter with first-match index capture
module seq_hit_counter #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             smp_en,
    input  logic             hit,
    input  logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] hit_count,
    output logic [IDX_W-1:0] first_hit_idx,
    output logic             hit_seen
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count     <= '0;
            first_hit_idx <= '0;
            hit_seen      <= 1'b0;
        end else if (clr) begin
            hit_count     <= '0;
            first_hit_idx <= '0;
            hit_seen      <= 1'b0;
        end else if (smp_en && hit) begin
            if (hit_count != {CNT_W{1'b1}})
                hit_count <= hit_count + CNT_W'(1);
            if (!hit_seen) begin
                first_hit_idx <= idx;
                hit_seen      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - feeds parallel words LSB first into a serial 10110 detector and tallies hits
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_word,
    output logic              load_ready,
    input  logic              keep_state,
    input  logic              abort,
    output logic              det_rst,
    output logic              det_inp,
    input  logic              det_outp,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [IDX_W-1:0]  first_hit_idx,
    output logic              hit_seen
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_t            state, state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              keep_r;
    logic              accept;
    logic              smp_en;
    logic [IDX_W-1:0]  smp_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // The detector output lags its input by one edge, so each sample belongs to the previous bit.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        det_inp    = 1'b0;
        det_rst    = rst;
        accept     = 1'b0;
        smp_en     = 1'b0;
        smp_idx    = idx - IDX_W'(1);
        case (state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept    = 1'b1;
                    state_nxt = keep_state ? ST_SHIFT : ST_PREP;
                end
            end
            ST_PREP: begin
                busy      = 1'b1;
                det_rst   = 1'b0;
                state_nxt = abort ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                det_inp = shreg[0];
                // On a carried-over scan the idx 0 sample catches matches straddling the word boundary.
                smp_en  = (idx != '0) || keep_r;
                if (idx == '0)
                    smp_idx = '0;
                if (abort)
                    state_nxt = ST_IDLE;
                else if (idx == LAST_IDX)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                smp_en    = 1'b1;
                smp_idx   = LAST_IDX;
                state_nxt = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg  <= '0;
            idx    <= '0;
            keep_r <= 1'b0;
        end else if (accept) begin
            shreg  <= load_word;
            idx    <= '0;
            keep_r <= keep_state;
        end else if (state == ST_SHIFT) begin
            shreg  <= shreg >> 1;
            idx    <= idx + IDX_W'(1);
        end
    end

    seq_hit_counter #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) u_hit_counter (
        .clk          (clk),
        .rst          (rst),
        .clr          (accept),
        .smp_en       (smp_en),
        .hit          (det_outp),
        .idx          (smp_idx),
        .hit_count    (hit_count),
        .first_hit_idx(first_hit_idx),
        .hit_seen     (hit_seen)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed bench for seq_scan_ctrl with a behavioural overlapping 10110 detector
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_word = 16'h0;
    logic        keep_state = 1'b0;
    logic        abort = 1'b0;
    logic        load_ready, det_rst, det_inp, det_outp, busy, done, hit_seen;
    logic [4:0]  hit_count;
    logic [3:0]  first_hit_idx;
    logic        s_load_ready, s_det_rst, s_det_inp, s_busy, s_done, s_hit_seen;
    logic [1:0]  s_hit_count;
    logic [3:0]  s_first_hit_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_word(load_word),
        .load_ready(load_ready), .keep_state(keep_state), .abort(abort),
        .det_rst(det_rst), .det_inp(det_inp), .det_outp(det_outp), .busy(busy),
        .done(done), .hit_count(hit_count), .first_hit_idx(first_hit_idx),
        .hit_seen(hit_seen)
    );

    // Narrow-counter copy sees identical stimulus and detector feedback.
    seq_scan_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_word(load_word),
        .load_ready(s_load_ready), .keep_state(keep_state), .abort(abort),
        .det_rst(s_det_rst), .det_inp(s_det_inp), .det_outp(det_outp), .busy(s_busy),
        .done(s_done), .hit_count(s_hit_count), .first_hit_idx(s_first_hit_idx),
        .hit_seen(s_hit_seen)
    );

    // Detector advances only while bits are being shifted, so its state carries across words.
    int       det_left;
    bit       det_pre;
    logic [4:0] hist;
    wire      det_en = (det_left > 0) && !det_pre;
    assign det_outp = (hist == 5'b10110);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_left <= 0;
            det_pre  <= 1'b0;
        end else if (abort && busy) begin
            det_left <= 0;
            det_pre  <= 1'b0;
        end else if (load_valid && load_ready) begin
            det_pre  <= !keep_state;
            det_left <= 16;
        end else if (det_pre) begin
            det_pre  <= 1'b0;
        end else if (det_left > 0) begin
            det_left <= det_left - 1;
        end
    end

    always @(posedge clk or negedge det_rst) begin
        if (!det_rst)
            hist <= 5'b0;
        else if (det_en)
            hist <= {hist[3:0], det_inp};
    end

    task automatic start_word(input logic [15:0] w, input logic k);
        load_valid = 1'b1;
        load_word  = w;
        keep_state = k;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        keep_state = 1'b0;
    endtask

    task automatic run_word(input logic [15:0] w, input logic k,
                            output int dc, output int dn, output int rl);
        dc = -1;
        dn = 0;
        rl = 0;
        start_word(w, k);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!det_rst) rl++;
            if (done) begin
                dn++;
                if (dc < 0) dc = c;
            end
            if (dc >= 0 && load_ready) break;
        end
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (det_inp !== 1'b0) begin n_err++; $display("FAIL reset_det_inp got %b want 0", det_inp); end
        n_cmp++; if (det_rst !== 1'b0) begin n_err++; $display("FAIL reset_det_rst got %b want 0", det_rst); end
        n_cmp++; if ({hit_seen, first_hit_idx, hit_count} !== 10'h0) begin n_err++;
            $display("FAIL reset_results got %b/%0d/%0d want 0/0/0", hit_seen, first_hit_idx, hit_count); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int dc, dn, rl;
        run_word(16'b1011011011011011, 1'b0, dc, dn, rl);
        n_cmp++; if (hit_count !== 5'd4) begin n_err++; $display("FAIL basic_count got %0d want 4", hit_count); end
        n_cmp++; if (first_hit_idx !== 4'd5) begin n_err++; $display("FAIL basic_first got %0d want 5", first_hit_idx); end
        n_cmp++; if (hit_seen !== 1'b1) begin n_err++; $display("FAIL basic_seen got %b want 1", hit_seen); end
        n_cmp++; if (dc !== 19) begin n_err++; $display("FAIL basic_done_cycle got %0d want 19", dc); end
        n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL basic_done_width got %0d want 1", dn); end
        n_cmp++; if (s_hit_count !== 2'd3) begin n_err++; $display("FAIL sat_count got %0d want 3", s_hit_count); end
        n_cmp++; if (s_first_hit_idx !== 4'd5) begin n_err++; $display("FAIL sat_first got %0d want 5", s_first_hit_idx); end
    endtask

    task automatic test_zero;
        int dc, dn, rl;
        run_word(16'h0000, 1'b0, dc, dn, rl);
        n_cmp++; if (hit_count !== 5'd0) begin n_err++; $display("FAIL zero_count got %0d want 0", hit_count); end
        n_cmp++; if (hit_seen !== 1'b0) begin n_err++; $display("FAIL zero_seen got %b want 0", hit_seen); end
        n_cmp++; if (first_hit_idx !== 4'd0) begin n_err++; $display("FAIL zero_first got %0d want 0", first_hit_idx); end
        n_cmp++; if (rl !== 1) begin n_err++; $display("FAIL zero_det_rst_low got %0d cycles want 1", rl); end
        n_cmp++; if (dc !== 19) begin n_err++; $display("FAIL zero_done_cycle got %0d want 19", dc); end
    endtask

    task automatic test_keep_state;
        int dc, dn, rl;
        run_word(16'hA000, 1'b0, dc, dn, rl);
        n_cmp++; if (hit_count !== 5'd0) begin n_err++; $display("FAIL keep_first_word got %0d want 0", hit_count); end
        run_word(16'h0001, 1'b1, dc, dn, rl);
        n_cmp++; if (hit_count !== 5'd1) begin n_err++; $display("FAIL keep_count got %0d want 1", hit_count); end
        n_cmp++; if (first_hit_idx !== 4'd1) begin n_err++; $display("FAIL keep_first got %0d want 1", first_hit_idx); end
        n_cmp++; if (dc !== 18) begin n_err++; $display("FAIL keep_done_cycle got %0d want 18", dc); end
        n_cmp++; if (rl !== 0) begin n_err++; $display("FAIL keep_det_rst_low got %0d want 0", rl); end
        run_word(16'hA000, 1'b0, dc, dn, rl);
        run_word(16'h0001, 1'b0, dc, dn, rl);
        n_cmp++; if (hit_count !== 5'd0) begin n_err++; $display("FAIL nokeep_count got %0d want 0", hit_count); end
    endtask

    task automatic test_abort;
        bit saw_done;
        start_word(16'b1011011011011011, 1'b0);
        for (int c = 1; c <= 8; c++) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", load_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (det_inp !== 1'b0) begin n_err++; $display("FAIL abort_det_inp got %b want 0", det_inp); end
        n_cmp++; if (hit_count !== 5'd1) begin n_err++; $display("FAIL abort_count got %0d want 1", hit_count); end
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got %b want 0", saw_done); end
        n_cmp++; if (hit_count !== 5'd1) begin n_err++; $display("FAIL abort_retained got %0d want 1", hit_count); end
    endtask

    task automatic test_reset_mid;
        int dc, dn, rl;
        start_word(16'b1011011011011011, 1'b0);
        for (int c = 1; c <= 12; c++) @(negedge clk);
        n_cmp++; if (det_inp !== 1'b1) begin n_err++; $display("FAIL mid_pre_det_inp got %b want 1", det_inp); end
        n_cmp++; if (hit_count !== 5'd2) begin n_err++; $display("FAIL mid_pre_count got %0d want 2", hit_count); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
        n_cmp++; if (det_inp !== 1'b0) begin n_err++; $display("FAIL mid_det_inp got %b want 0", det_inp); end
        n_cmp++; if (hit_count !== 5'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", hit_count); end
        n_cmp++; if (det_rst !== 1'b0) begin n_err++; $display("FAIL mid_det_rst got %b want 0", det_rst); end
        @(negedge clk);
        rst = 1'b1;
        run_word(16'b1011011011011011, 1'b0, dc, dn, rl);
        n_cmp++; if (hit_count !== 5'd4) begin n_err++; $display("FAIL mid_after_count got %0d want 4", hit_count); end
        n_cmp++; if (dc !== 19) begin n_err++; $display("FAIL mid_after_done got %0d want 19", dc); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_keep_state;
        test_abort;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
